hazard_unit: RTL

// Consumer of the pipeline controller's hazard-relevant outputs and producer of FlushE and the datapath stall/flush/forward controls.

---
 rtl/hazard_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard resolution: operand forwarding, load-use stall, branch flush,
// and a RUN/WAIT/ERR freeze FSM for multi-cycle data-memory accesses.
module hazard_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcb0E,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int CNT_BITS = $clog2(TIMEOUT + 1);
  localparam int WAIT_W   = (CNT_BITS > 5) ? CNT_BITS : 5;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } memState_t;

  memState_t         state;
  logic [WAIT_W-1:0] waitCnt;
  logic              memErr;
  logic [CNT_W-1:0]  stallCnt;
  logic [CNT_W-1:0]  flushCnt;

  logic              memStall;
  logic              lwStall;
  logic [1:0]        fwdA;
  logic [1:0]        fwdB;

  // M-stage result is newer than W-stage, so it wins when both match.
  function automatic logic [1:0] fwdSel(
    input logic [4:0] rs,
    input logic       regWriteM,
    input logic [4:0] rdM,
    input logic       regWriteW,
    input logic [4:0] rdW
  );
    if (regWriteM && (rdM != 5'd0) && (rdM == rs))
      return 2'b10;
    else if (regWriteW && (rdW != 5'd0) && (rdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwdA    = fwdSel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    fwdB    = fwdSel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    lwStall = ResultSrcb0E && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // The first missing cycle stalls from RUN without waiting for a state change.
  always_comb begin
    memStall = 1'b0;
    unique case (state)
      RUN, WAIT: memStall = MemReqM && !MemReadyM;
      ERR:       memStall = 1'b1;
      default:   memStall = 1'b1;
    endcase
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (memStall) begin
      // Whole pipe frozen; E is re-evaluated once memory releases.
      ForwardAE = fwdA;
      ForwardBE = fwdB;
      StallF    = 1'b1;
      StallD    = 1'b1;
      StallE    = 1'b1;
      StallM    = 1'b1;
      FlushW    = 1'b1;
    end else begin
      ForwardAE = fwdA;
      ForwardBE = fwdB;
      StallF    = lwStall;
      StallD    = lwStall;
      FlushD    = PCSrcE;
      FlushE    = lwStall || PCSrcE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (memStall) begin
            state   <= WAIT;
            waitCnt <= WAIT_W'(1);
          end
        end
        WAIT: begin
          if (MemReadyM || !MemReqM) begin
            state   <= RUN;
            waitCnt <= '0;
          end else if (waitCnt == WAIT_W'(TIMEOUT)) begin
            state  <= ERR;
            memErr <= 1'b1;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        ERR: begin
          memErr <= 1'b1;
        end
        default: begin
          state  <= ERR;
          memErr <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (StallF && (stallCnt != '1))
        stallCnt <= stallCnt + CNT_W'(1);
      if (FlushE && (flushCnt != '1))
        flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  assign MemErr     = memErr;
  assign StallCount = stallCnt;
  assign FlushCount = flushCnt;

endmodule
